// File: rtl/fpgc_instr_pkg.sv
// Instruction word layout and format codes, shared by the encoder and decoder.
package fpgc_instr_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 27;

  localparam int OP_LSB    = 28;
  localparam int OP_W      = 4;
  localparam int CE_BIT    = 27;
  localparam int OPC_LSB   = 23;
  localparam int OPC_W     = 4;
  localparam int C11_LSB   = 12;
  localparam int C11_W     = 11;
  localparam int C16_LSB   = 12;
  localparam int C16_W     = 16;
  localparam int C27_LSB   = 1;
  localparam int C27_W     = 27;
  localparam int AREG_LSB  = 8;
  localparam int BREG_LSB  = 4;
  localparam int DREG_LSB  = 0;
  localparam int REG_W     = 4;
  localparam int FLAG0_BIT = 0;

  localparam logic [1:0] FMT_ARITH = 2'd0;
  localparam logic [1:0] FMT_C16   = 2'd1;
  localparam logic [1:0] FMT_C27   = 2'd2;
  localparam logic [1:0] FMT_RSVD  = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0]  instr_op;
    logic             ce;
    logic [OPC_W-1:0] opcode;
    logic [C11_W-1:0] const11;
    logic [C16_W-1:0] const16;
    logic [C27_W-1:0] const27;
    logic [REG_W-1:0] areg;
    logic [REG_W-1:0] breg;
    logic [REG_W-1:0] dreg;
    logic             flag0;
  } instr_fields_t;

  function automatic logic [INSTR_W-1:0] encode_instr(input logic [1:0] fmt,
                                                      input instr_fields_t f);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_LSB +: OP_W] = f.instr_op;
    case (fmt)
      FMT_ARITH: begin
        w[CE_BIT]               = f.ce;
        w[OPC_LSB +: OPC_W]     = f.opcode;
        w[C11_LSB +: C11_W]     = f.const11;
        w[AREG_LSB +: REG_W]    = f.areg;
        w[BREG_LSB +: REG_W]    = f.breg;
        w[DREG_LSB +: REG_W]    = f.dreg;
      end
      FMT_C16: begin
        w[C16_LSB +: C16_W]     = f.const16;
        w[AREG_LSB +: REG_W]    = f.areg;
        w[BREG_LSB +: REG_W]    = f.breg;
        w[DREG_LSB +: REG_W]    = f.dreg;
      end
      FMT_C27: begin
        w[C27_LSB +: C27_W]     = f.const27;
        w[FLAG0_BIT]            = f.flag0;
      end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// 4-deep, 32-bit word FIFO; head entry is read straight from storage registers.
module instr_fifo
  import fpgc_instr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [INSTR_W-1:0] din_i,
  input  logic               pop_i,
  output logic [INSTR_W-1:0] dout_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [3:0][INSTR_W-1:0] mem_q;
  logic [1:0]              wr_ptr_q, rd_ptr_q;
  logic [2:0]              cnt_q;
  logic                    do_push, do_pop;

  assign full_o  = (cnt_q == 3'd4);
  assign empty_o = (cnt_q == 3'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      // simultaneous push/pop leaves occupancy unchanged
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 3'd1;
        2'b01:   cnt_q <= cnt_q - 3'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs instruction field sets into 32-bit words and streams them to
// sequential memory addresses through a small FIFO.
module instruction_encoder
  import fpgc_instr_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               finish,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         fmt,
  input  logic [OP_W-1:0]    instrOP,
  input  logic               ce,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [C11_W-1:0]   const11,
  input  logic [C16_W-1:0]   const16,
  input  logic [C27_W-1:0]   const27,
  input  logic [REG_W-1:0]   areg,
  input  logic [REG_W-1:0]   breg,
  input  logic [REG_W-1:0]   dreg,
  input  logic               flag0,
  output logic               wr_req,
  input  logic               wr_ack,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [INSTR_W-1:0] wr_data,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  count,
  output logic               err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, count_q;
  logic               err_q;
  logic               fifo_full, fifo_empty;
  logic [INSTR_W-1:0] fifo_dout, enc_word;
  logic               accept, push, pop, start_go;
  instr_fields_t      fields;

  assign fields = '{instr_op: instrOP, ce: ce, opcode: opcode, const11: const11,
                    const16: const16, const27: const27, areg: areg, breg: breg,
                    dreg: dreg, flag0: flag0};
  assign enc_word = encode_instr(fmt, fields);

  // ready depends only on registered state so it never loops through wr_ack
  assign in_ready = (state_q == ST_RUN) && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (fmt != FMT_RSVD);
  assign wr_req   = (state_q != ST_IDLE) && !fifo_empty;
  assign pop      = wr_req && wr_ack;
  assign start_go = start && (state_q == ST_IDLE);

  assign wr_addr = addr_q;
  assign wr_data = wr_req ? fifo_dout : '0;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DRAIN) && fifo_empty;
  assign count   = count_q;
  assign err     = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)      state_d = ST_RUN;
      ST_RUN:   if (finish)     state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_go) begin
        addr_q  <= base_addr;
        count_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (pop) begin
          addr_q  <= addr_q + 27'd1;
          count_q <= count_q + 27'd1;
        end
        if (accept && (fmt == FMT_RSVD)) err_q <= 1'b1;
      end
    end
  end

  instr_fifo u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .din_i   (enc_word),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed scenarios for instruction_encoder with hand-computed expected words.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, finish;
  logic [26:0] base_addr;
  logic        in_valid, in_ready;
  logic [1:0]  fmt;
  logic [3:0]  instrOP, opcode, areg, breg, dreg;
  logic        ce, flag0;
  logic [10:0] const11;
  logic [15:0] const16;
  logic [26:0] const27;
  logic        wr_req, wr_ack;
  logic [26:0] wr_addr, count;
  logic [31:0] wr_data;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_encoder dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .base_addr(base_addr), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .instrOP(instrOP), .ce(ce), .opcode(opcode),
    .const11(const11), .const16(const16), .const27(const27),
    .areg(areg), .breg(breg), .dreg(dreg), .flag0(flag0),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .count(count), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; finish = 0; base_addr = '0; in_valid = 0; fmt = 0;
    instrOP = 0; ce = 0; opcode = 0; const11 = 0; const16 = 0; const27 = 0;
    areg = 0; breg = 0; dreg = 0; flag0 = 0; wr_ack = 0;
  endtask

  task automatic set_c27(input logic [26:0] k);
    fmt = 2'd2; instrOP = 4'h9; const27 = k; flag0 = 1'b0;
  endtask

  task automatic do_start(input logic [26:0] base);
    base_addr = base; start = 1; tick(); start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    #3;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req got %b exp 0", wr_req); end
    checks++; if ({wr_addr, count, wr_data} !== '0) begin errors++; $display("FAIL reset_regs got %h/%h/%h exp 0", wr_addr, count, wr_data); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, err}); end
    tick(); tick();
    reset = 1;
    tick();
  endtask

  task automatic test_arith();
    do_start(27'h100);
    checks++; if ({busy, in_ready} !== 2'b11) begin errors++; $display("FAIL run_entry got %b exp 11", {busy, in_ready}); end
    fmt = 2'd0; instrOP = 4'h1; ce = 1; opcode = 4'h3; const11 = 11'd5;
    areg = 4'h1; breg = 4'h2; dreg = 4'h3; in_valid = 1;
    checks++; if (wr_req !== 1'b0) begin errors++; $display("FAIL arith_no_early_req got %b exp 0", wr_req); end
    tick(); in_valid = 0;
    checks++; if (wr_req !== 1'b1) begin errors++; $display("FAIL arith_req got %b exp 1", wr_req); end
    checks++; if (wr_addr !== 27'h100) begin errors++; $display("FAIL arith_addr got %h exp 100", wr_addr); end
    checks++; if (wr_data !== 32'h19805123) begin errors++; $display("FAIL arith_data got %h exp 19805123", wr_data); end
    tick();
    checks++; if (wr_data !== 32'h19805123) begin errors++; $display("FAIL arith_hold got %h exp 19805123", wr_data); end
    wr_ack = 1; tick(); wr_ack = 0;
    checks++; if (count !== 27'd1 || wr_addr !== 27'h101) begin errors++; $display("FAIL arith_ack got cnt %h addr %h exp 1/101", count, wr_addr); end
  endtask

  task automatic test_formats();
    fmt = 2'd1; instrOP = 4'hD; const16 = 16'hBEEF; areg = 0; breg = 4; dreg = 5;
    in_valid = 1; tick(); in_valid = 0;
    checks++; if (wr_data !== 32'hDBEEF045) begin errors++; $display("FAIL c16_data got %h exp DBEEF045", wr_data); end
    wr_ack = 1; tick(); wr_ack = 0;
    fmt = 2'd2; instrOP = 4'h9; const27 = 27'h10; flag0 = 1;
    in_valid = 1; tick(); in_valid = 0;
    checks++; if (wr_data !== 32'h90000021) begin errors++; $display("FAIL c27_data got %h exp 90000021", wr_data); end
    checks++; if (wr_addr !== 27'h102) begin errors++; $display("FAIL c27_addr got %h exp 102", wr_addr); end
    wr_ack = 1; tick(); wr_ack = 0;
    checks++; if (count !== 27'd3) begin errors++; $display("FAIL fmt_count got %h exp 3", count); end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    logic [26:0] k = 27'd1;
    logic took;
    set_c27(k); in_valid = 1;
    repeat (6) begin
      took = in_ready;
      tick();
      if (took) begin acc++; k = k + 27'd1; set_c27(k); end
    end
    checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted got %0d exp 4", acc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", in_ready); end
    in_valid = 0; wr_ack = 1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (wr_req !== 1'b1 || wr_addr !== 27'h103 + 27'(j) || wr_data !== (32'h90000000 | (32'(j + 1) << 1))) begin
        errors++; $display("FAIL bp_word%0d got %b %h %h", j, wr_req, wr_addr, wr_data);
      end
      tick();
    end
    wr_ack = 0;
    checks++; if (wr_req !== 1'b0 || count !== 27'd7) begin errors++; $display("FAIL bp_drained got req %b cnt %h exp 0/7", wr_req, count); end
  endtask

  task automatic test_err();
    set_c27(27'h55); in_valid = 1; tick();
    fmt = 2'd3; tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
    set_c27(27'h56); tick(); in_valid = 0;
    wr_ack = 1;
    checks++; if (wr_addr !== 27'h107 || wr_data !== 32'h900000AA) begin errors++; $display("FAIL err_w0 got %h %h exp 107 900000AA", wr_addr, wr_data); end
    tick();
    checks++; if (wr_addr !== 27'h108 || wr_data !== 32'h900000AC) begin errors++; $display("FAIL err_w1 got %h %h exp 108 900000AC", wr_addr, wr_data); end
    tick(); wr_ack = 0;
    checks++; if (wr_req !== 1'b0 || count !== 27'd9 || err !== 1'b1) begin errors++; $display("FAIL err_end got %b %h %b exp 0 9 1", wr_req, count, err); end
    finish = 1; tick(); finish = 0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL err_done got %b exp 1", done); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL err_idle got %b%b exp 00", busy, done); end
  endtask

  task automatic test_start_finish();
    base_addr = 27'h40; start = 1; finish = 1; tick(); start = 0; finish = 0;
    checks++; if ({busy, in_ready, done} !== 3'b110) begin errors++; $display("FAIL sf_run got %b exp 110", {busy, in_ready, done}); end
    checks++; if (err !== 1'b0 || count !== 27'd0 || wr_addr !== 27'h40) begin errors++; $display("FAIL sf_clear got %b %h %h exp 0 0 40", err, count, wr_addr); end
    start = 1; base_addr = 27'h77; tick(); start = 0;
    checks++; if (wr_addr !== 27'h40) begin errors++; $display("FAIL sf_start_ignored got %h exp 40", wr_addr); end
    finish = 1; tick(); finish = 0;
    checks++; if (done !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL sf_done got %b ready %b exp 1 0", done, in_ready); end
    tick();
  endtask

  task automatic test_wrap();
    do_start(27'h7FFFFFE);
    in_valid = 1;
    for (int j = 0; j < 3; j++) begin set_c27(27'(j + 1)); tick(); end
    in_valid = 0;
    finish = 1; tick(); finish = 0;
    checks++; if ({busy, done, in_ready} !== 3'b100) begin errors++; $display("FAIL wrap_drain got %b exp 100", {busy, done, in_ready}); end
    wr_ack = 1;
    checks++; if (wr_addr !== 27'h7FFFFFE) begin errors++; $display("FAIL wrap_a0 got %h exp 7FFFFFE", wr_addr); end
    tick();
    checks++; if (wr_addr !== 27'h7FFFFFF || done !== 1'b0) begin errors++; $display("FAIL wrap_a1 got %h done %b exp 7FFFFFF 0", wr_addr, done); end
    tick();
    checks++; if (wr_addr !== 27'h0 || wr_data !== 32'h90000006 || done !== 1'b0) begin errors++; $display("FAIL wrap_a2 got %h %h %b exp 0 90000006 0", wr_addr, wr_data, done); end
    tick();
    checks++; if (done !== 1'b1 || wr_req !== 1'b0 || count !== 27'd3) begin errors++; $display("FAIL wrap_done got %b %b %h exp 1 0 3", done, wr_req, count); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || count !== 27'd3 || wr_addr !== 27'd1) begin errors++; $display("FAIL wrap_idle got %b %b %h %h exp 0 0 3 1", busy, done, count, wr_addr); end
    wr_ack = 0;
  endtask

  task automatic test_reset_drain();
    do_start(27'h200);
    in_valid = 1;
    set_c27(27'h11); tick();
    set_c27(27'h12); tick();
    in_valid = 0;
    finish = 1; tick(); finish = 0;
    checks++; if (busy !== 1'b1 || wr_req !== 1'b1) begin errors++; $display("FAIL rd_pre got %b%b exp 11", busy, wr_req); end
    #2 reset = 0;
    #1;
    checks++; if ({busy, done, wr_req, in_ready, err} !== 5'b0) begin errors++; $display("FAIL rd_flags got %b exp 00000", {busy, done, wr_req, in_ready, err}); end
    checks++; if ({wr_addr, count, wr_data} !== '0) begin errors++; $display("FAIL rd_regs got %h %h %h exp 0", wr_addr, count, wr_data); end
    tick(); tick();
    #2 reset = 1;
    wr_ack = 1;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if (wr_req !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_after%0d got %b%b%b exp 000", j, wr_req, done, busy); end
    end
    wr_ack = 0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_formats();
    test_back_to_back();
    test_err();
    test_start_finish();
    test_wrap();
    test_reset_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 clk  in  1  single system clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately, released synchronously to clk.
REQ-003 start  in  1  one-cycle pulse; loads base_addr, clears counters and err, enters RUN.
REQ-004 finish  in  1  one-cycle pulse; ends input phase, enters DRAIN.
REQ-005 base_addr  in  27  first write address.
REQ-006 in_valid / in_ready  in / out  1 / 1  field-set handshake; transfer when both high at clk edge.
REQ-007 fmt  in  2  encoding format: 0 ARITH, 1 C16, 2 C27, 3 reserved.
REQ-008 instrOP  in  4; ce  in  1; opcode  in  4; const11  in  11; const16  in  16; const27  in  27; areg, breg, dreg  in  4 each; flag0  in  1 (oe/n1/sig bit).
REQ-009 wr_req / wr_ack  out / in  1 / 1  memory write handshake.
REQ-010 wr_addr  out  27; wr_data  out  32.
REQ-011 busy  out  1  high in RUN or DRAIN; done  out  1  one-cycle pulse on DRAIN exit.
REQ-012 count  out  27  words written since start; err  out  1  sticky reserved-format flag.

Function
REQ-013 Field placement: instrOP->[31:28] all formats.
REQ-014 ARITH: ce->[27], opcode->[26:23], const11->[22:12], areg->[11:8], breg->[7:4], dreg->[3:0].
REQ-015 C16: const16->[27:12], areg/breg/dreg->[11:0] as ARITH.
REQ-016 C27: const27->[27:1], flag0->[0].
REQ-017 fmt 3: handshake completes, no word enqueued, err set; err clears only on start or reset.
REQ-018 States IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN on finish; DRAIN->IDLE when FIFO empty and no write outstanding, pulsing done that cycle.
REQ-019 start ignored outside IDLE; finish ignored outside RUN; start and finish same cycle in IDLE: start wins, finish ignored.
REQ-020 in_ready = RUN and FIFO not full, from registered state only (not combinational on wr_ack); low in IDLE and DRAIN.
REQ-021 Encoded words buffered in 4-entry FIFO; accepted word presented on wr_data no earlier than the cycle after acceptance.
REQ-022 wr_req high whenever FIFO non-empty in RUN/DRAIN; wr_addr/wr_data stable while wr_req high and wr_ack low.
REQ-023 wr_ack with wr_req high: pop FIFO, wr_addr+1, count+1; next word may follow with no idle cycle.
REQ-024 wr_ack while wr_req low is ignored.
REQ-025 wr_addr wraps 27'h7FFFFFF -> 0; count wraps likewise.
REQ-026 Push and pop in same cycle: occupancy unchanged, order preserved.

Reset
REQ-027 On reset: state IDLE, FIFO empty, in_ready 0, wr_req 0, wr_addr 0, wr_data 0, count 0, err 0, busy 0, done 0.
REQ-028 Reset mid-write discards FIFO contents and any unacknowledged write; no done pulse.

Structure
REQ-029 Shared package fpgc_instr_pkg holds field bit positions/widths (instrOP, ce, opcode, const11/16/27, areg/breg/dreg, flag0) and FMT_* constants, shared with the decoder.
REQ-030 One sub-module instr_fifo (32-bit, depth 4, full/empty, registered output).

Verification
REQ-031 start base 27'h100; ARITH instrOP=1, ce=1, opcode=3, const11=5, areg=1, breg=2, dreg=3; ack -> wr_addr 27'h100, wr_data 32'h19805123, count 1.
REQ-032 C16 instrOP=D, const16=BEEF, areg=0, breg=4, dreg=5 -> 32'hDBEEF045; C27 instrOP=9, const27=27'h10, flag0=1 -> 32'h90000021.
REQ-033 wr_ack held low, 5 valid inputs -> 4 accepted, in_ready low; release ack -> 4 words in order, consecutive addresses.
REQ-034 fmt=3 mid-stream -> err=1, count and addresses skip nothing; err cleared by next start.
REQ-035 base 27'h7FFFFFE, 3 words -> addresses 7FFFFFE, 7FFFFFF, 0; finish -> done pulses once after last ack, busy falls.
REQ-036 reset low during DRAIN with 2 words queued -> all outputs at reset values immediately, no further wr_req, no done.
